// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB requester slice.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned c_DEFAULT_AW = 32;
    localparam int unsigned c_DEFAULT_DW = 32;

    localparam logic [31:0] c_UART_TX_ADDR = 32'd0;
    localparam logic [31:0] c_UART_RX_ADDR = 32'd1;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Saturating wait-state counter with clear, enable and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int unsigned            c_CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0]        c_LIMIT = c_CW'(TIMEOUT);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {c_CW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero limit means the watchdog never fires.
    if (TIMEOUT == 0) begin : g_wdog_off
        assign o_timeout = 1'b0;
    end else begin : g_wdog_on
        assign o_timeout = (r_count >= c_LIMIT);
    end

endmodule
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester
// Description : Single-command APB3/APB4 initiator with wait-state watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned AW      = c_DEFAULT_AW,
    parameter int unsigned DW      = c_DEFAULT_DW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_strb,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    output logic [AW-1:0]   padd,
    output logic [DW-1:0]   pdata,
    output logic            psel,
    output logic            pen,
    output logic            pwr,
    output logic [DW/8-1:0] pstrb,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslverr
);

    apb_state_e r_state;
    apb_state_e w_state_next;

    logic w_hs;
    logic w_done;
    logic w_abort;
    logic w_wait;
    logic w_timeout;

    logic [AW-1:0]   r_padd;
    logic [DW-1:0]   r_pdata;
    logic [DW/8-1:0] r_pstrb;
    logic            r_pwr;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_rsp_err;
    logic            r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        psel         = 1'b0;
        pen          = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                psel         = 1'b1;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                psel = 1'b1;
                pen  = 1'b1;
                if (pready) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_hs   = cmd_valid & cmd_ready;
    assign w_wait = (r_state == ACCESS) & ~pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_hs),
        .i_en      (w_wait),
        .o_timeout (w_timeout)
    );

    // Reads never expose write data or strobes on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_padd        <= '0;
            r_pdata       <= '0;
            r_pstrb       <= '0;
            r_pwr         <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_hs) begin
                r_padd  <= cmd_addr;
                r_pwr   <= cmd_write;
                r_pdata <= cmd_write ? cmd_wdata : '0;
                r_pstrb <= cmd_write ? cmd_strb  : '0;
            end
            r_rsp_valid   <= w_done | w_abort;
            r_rsp_err     <= (w_done & pslverr) | w_abort;
            r_rsp_timeout <= w_abort;
            r_rsp_rdata   <= (w_done && !r_pwr && !pslverr) ? prdata : '0;
        end
    end

    assign padd        = r_padd;
    assign pdata       = r_pdata;
    assign pstrb       = r_pstrb;
    assign pwr         = r_pwr;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_requester
// Description : Directed scoreboard bench for apb_requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_requester;
    import apb_pkg::*;

    localparam int unsigned c_TO = 16;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] padd;
    logic [31:0] pdata;
    logic        psel;
    logic        pen;
    logic        pwr;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    apb_requester #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (c_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .padd        (padd),
        .pdata       (pdata),
        .psel        (psel),
        .pen         (pen),
        .pwr         (pwr),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any response that appears.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("rsp_rdata",   rsp_rdata,          e.rdata);
                check("rsp_err",     32'(rsp_err),       32'(e.err));
                check("rsp_timeout", 32'(rsp_timeout),   32'(e.tmo));
            end
        end
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = 4'hF;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        tick();
        tick();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_psel",      32'(psel),      32'd0);
        check("rst_pen",       32'(pen),       32'd0);
        check("rst_pwr",       32'(pwr),       32'd0);
        check("rst_padd",      padd,           32'd0);
        check("rst_pdata",     pdata,          32'd0);
        check("rst_pstrb",     32'(pstrb),     32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait write to UART TX
        drive_cmd(1'b1, c_UART_TX_ADDR, 32'h5F);
        q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_psel",  32'(psel),      32'd1);
        check("wr_setup_pen",   32'(pen),       32'd0);
        check("wr_setup_ready", 32'(cmd_ready), 32'd0);
        check("wr_pwr",         32'(pwr),       32'd1);
        check("wr_pstrb",       32'(pstrb),     32'hF);
        check("wr_pdata",       pdata,          32'h5F);
        check("wr_padd",        padd,           32'd0);
        tick();
        check("wr_access_psel", 32'(psel), 32'd1);
        check("wr_access_pen",  32'(pen),  32'd1);
        tick();
        check("wr_rsp_valid",   32'(rsp_valid), 32'd1);
        check("wr_idle_psel",   32'(psel),      32'd0);
        check("wr_idle_ready",  32'(cmd_ready), 32'd1);

        // Read UART RX with four wait states; error/data ignored while not ready
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hEE;
        drive_cmd(1'b0, c_UART_RX_ADDR, 32'h123);
        q.push_back('{rdata: 32'hF5, err: 1'b0, tmo: 1'b0});
        tick();
        cmd_valid = 1'b0;
        check("rd_pdata_zero", pdata,      32'd0);
        check("rd_pstrb_zero", 32'(pstrb), 32'd0);
        check("rd_pwr",        32'(pwr),   32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_wait_padd",  padd,           32'd1);
            check("rd_wait_pen",   32'(pen),       32'd1);
            check("rd_wait_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'hF5;
        check("rd_last_padd", padd, 32'd1);
        tick();
        check("rd_rsp_valid_at7", 32'(rsp_valid), 32'd1);

        // Slave error on read
        pslverr = 1'b1;
        prdata  = 32'hAA;
        drive_cmd(1'b0, c_UART_RX_ADDR, 32'h0);
        q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("err_rsp_valid", 32'(rsp_valid), 32'd1);
        pslverr = 1'b0;

        // Watchdog abort, then a normal command
        pready = 1'b0;
        drive_cmd(1'b0, c_UART_RX_ADDR, 32'h0);
        q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b1});
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int k = 1; k <= int'(c_TO); k++) begin
            tick();
            check("to_wait_valid", 32'(rsp_valid), 32'd0);
            check("to_wait_psel",  32'(psel),      32'd1);
        end
        tick();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_psel_drop", 32'(psel),      32'd0);
        pready = 1'b1;
        drive_cmd(1'b1, c_UART_TX_ADDR, 32'h77);
        q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("post_to_rsp_valid", 32'(rsp_valid), 32'd1);

        // Back-to-back writes with cmd_valid held
        drive_cmd(1'b1, c_UART_TX_ADDR, 32'h11);
        q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
        tick();
        cmd_wdata = 32'h22;
        q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
        check("b2b_setup_ready", 32'(cmd_ready), 32'd0);
        check("b2b_pdata1",      pdata,          32'h11);
        tick();
        check("b2b_access_pdata1", pdata, 32'h11);
        tick();
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp1_ready", 32'(cmd_ready), 32'd1);
        check("b2b_idle_psel",  32'(psel),      32'd0);
        tick();
        cmd_valid = 1'b0;
        check("b2b_setup2_psel", 32'(psel), 32'd1);
        check("b2b_setup2_pen",  32'(pen),  32'd0);
        check("b2b_pdata2",      pdata,     32'h22);
        tick();
        tick();
        check("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);

        // Reset during ACCESS
        pready = 1'b0;
        drive_cmd(1'b1, 32'h40, 32'hDEAD);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rst_mid_pen_before", 32'(pen), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_psel",   32'(psel),        32'd0);
        check("rst_mid_pen",    32'(pen),         32'd0);
        check("rst_mid_valid",  32'(rsp_valid),   32'd0);
        check("rst_mid_padd",   padd,             32'd0);
        check("rst_mid_pdata",  pdata,            32'd0);
        check("rst_mid_pstrb",  32'(pstrb),       32'd0);
        check("rst_mid_pwr",    32'(pwr),         32'd0);
        check("rst_mid_ready",  32'(cmd_ready),   32'd1);
        check("rst_mid_err",    32'(rsp_err),     32'd0);
        check("rst_mid_tmo",    32'(rsp_timeout), 32'd0);
        rst    = 1'b0;
        pready = 1'b1;
        tick();
        tick();
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);

        check("sb_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
